// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, runs a single-outstanding request handshake to
// instruction memory and holds the fetched word and its PC for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h01000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP, S_ERR} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        redirect_ok;
  logic        redirect_bad;
  logic [31:0] target_pc;

  assign redirect_ok  = redirect_en && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect_en && (redirect_pc[1:0] != 2'b00);
  assign target_pc    = redirect_ok ? redirect_pc : pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      inst_out     <= NOP_INST;
      pc_out       <= RESET_PC;
      inst_valid   <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect_bad) begin
      // A misaligned target is fatal until reset; any in-flight ack is abandoned.
      state_reg    <= S_ERR;
      misalign_err <= 1'b1;
      inst_valid   <= 1'b0;
      inst_out     <= NOP_INST;
      imem_req     <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (!imem_req) begin
            // Idle slot (after reset or a redirect that hit an ack): issue now.
            pc_reg    <= target_pc;
            imem_addr <= target_pc;
            imem_req  <= 1'b1;
          end else if (redirect_ok) begin
            pc_reg <= redirect_pc;
            if (imem_ack) begin
              imem_req <= 1'b0;
            end else begin
              state_reg <= S_DROP;
            end
          end else if (imem_ack) begin
            inst_out   <= imem_rdata;
            pc_out     <= pc_reg;
            inst_valid <= 1'b1;
            pc_reg     <= pc_reg + 32'd4;
            imem_req   <= 1'b0;
            state_reg  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_ok || inst_ready) begin
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            pc_reg     <= target_pc;
            imem_addr  <= target_pc;
            imem_req   <= 1'b1;
            state_reg  <= S_REQ;
          end
        end
        S_DROP: begin
          // Address stays on the bus until the stale word arrives and is discarded.
          pc_reg <= target_pc;
          if (imem_ack) begin
            imem_addr <= target_pc;
            imem_req  <= 1'b1;
            state_reg <= S_REQ;
          end
        end
        S_ERR: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run scored against a
// program-order model (expected PC stream, redirects, memory contents as a function).
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h01000000;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int wait_cnt = 0;

  instr_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h01000000) return 32'h00500093;
    if (addr == 32'h01000004) return 32'h00A00113;
    return {addr[15:0] ^ 16'h5A5A, addr[31:16] ^ 16'h0F0F};
  endfunction

  // Memory: acks a request mem_lat cycles after it is first seen high.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (imem_ack) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
      if (imem_req) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    inst_ready  = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_req: req=%b addr=%h, expected req=0 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    checks++;
    if (inst_out !== NOP_INST || pc_out !== RESET_PC) begin
      errors++; $display("FAIL reset_regs: inst=%h pc=%h, expected inst=%h pc=%h", inst_out, pc_out, NOP_INST, RESET_PC);
    end
    checks++;
    if (inst_valid !== 1'b0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b err=%b, expected 0 0", inst_valid, misalign_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_no_early_req: req=%b, expected 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_first_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] got_pc [2];
    logic [31:0] got_inst [2];
    int run [2];
    int n;
    logic prev_v;
    got_pc = '{32'h0, 32'h0}; got_inst = '{32'h0, 32'h0}; run = '{0, 0};
    mem_lat = 2;
    do_reset();
    inst_ready = 1'b1;
    n = 0; prev_v = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (inst_valid) begin
        if (!prev_v) begin
          if (n < 2) begin got_pc[n] = pc_out; got_inst[n] = inst_out; end
          n++;
        end
        if (n >= 1 && n <= 2) run[n-1]++;
      end
      prev_v = inst_valid;
      if (n >= 2 && !inst_valid) break;
    end
    checks++;
    if (n < 2) begin errors++; $display("FAIL basic_count: got %0d instructions, expected 2", n); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_pc[k] !== RESET_PC + 32'(4 * k) || got_inst[k] !== mem_word(RESET_PC + 32'(4 * k))) begin
        errors++; $display("FAIL basic_word%0d: pc=%h inst=%h, expected pc=%h inst=%h", k, got_pc[k], got_inst[k],
                           RESET_PC + 32'(4 * k), mem_word(RESET_PC + 32'(4 * k)));
      end
      checks++;
      if (run[k] != 1) begin errors++; $display("FAIL basic_valid_len%0d: %0d cycles, expected 1", k, run[k]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] s_inst, s_pc;
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_wait_valid: valid=%b, expected 1", inst_valid); end
    s_inst = inst_out; s_pc = pc_out;
    checks++;
    if (s_pc !== RESET_PC || s_inst !== 32'h00500093) begin
      errors++; $display("FAIL stall_word: pc=%h inst=%h, expected pc=%h inst=00500093", s_pc, s_inst, RESET_PC);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_out !== s_inst || pc_out !== s_pc) begin
        errors++; $display("FAIL stall_frozen%0d: valid=%b req=%b inst=%h pc=%h, expected valid=1 req=0 inst=%h pc=%h",
                           i, inst_valid, imem_req, inst_out, pc_out, s_inst, s_pc);
      end
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd4 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                         imem_req, imem_addr, inst_valid, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_redirect_req();
    logic [31:0] old_addr;
    logic acked, seen_new;
    mem_lat = 3;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    old_addr = imem_addr;
    @(posedge clk); #1;
    redirect_en = 1'b1; redirect_pc = 32'h01000100;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    acked = 1'b0; seen_new = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr === 32'h01000100) begin seen_new = 1'b1; break; end
      checks++;
      if (imem_req && imem_addr !== old_addr) begin
        errors++; $display("FAIL redir_req_addr_held: addr=%h, expected %h", imem_addr, old_addr);
      end
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++; $display("FAIL redir_req_stale_word: valid=%b pc=%h, expected valid=0", inst_valid, pc_out);
      end
      if (imem_req && imem_ack) acked = 1'b1;
    end
    checks++;
    if (!seen_new || !acked) begin
      errors++; $display("FAIL redir_req_new_addr: seen_new=%b acked_before=%b, expected 1 1", seen_new, acked);
    end
    for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h01000100 || inst_out !== mem_word(32'h01000100)) begin
      errors++; $display("FAIL redir_req_first_word: valid=%b pc=%h inst=%h, expected 1 01000100 %h",
                         inst_valid, pc_out, inst_out, mem_word(32'h01000100));
    end
  endtask

  task automatic test_redirect_ack();
    logic seen_req;
    mem_lat = 2;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    @(posedge clk); #1;
    redirect_en = 1'b1; redirect_pc = 32'h01000200;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL redir_ack_gap: req=%b valid=%b, expected 0 0", imem_req, inst_valid);
    end
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_ack_dropped_valid: valid=%b pc=%h, expected 0", inst_valid, pc_out); end
      if (imem_req) begin seen_req = 1'b1; break; end
    end
    checks++;
    if (!seen_req || imem_addr !== 32'h01000200) begin
      errors++; $display("FAIL redir_ack_next_req: req_seen=%b addr=%h, expected 1 01000200", seen_req, imem_addr);
    end
    for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h01000200) begin
      errors++; $display("FAIL redir_ack_word: valid=%b pc=%h, expected 1 01000200", inst_valid, pc_out);
    end
  endtask

  task automatic test_redirect_hold();
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    redirect_en = 1'b1; redirect_pc = 32'h01000300; inst_ready = 1'b1;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== NOP_INST) begin
      errors++; $display("FAIL redir_hold_clear: valid=%b inst=%h, expected 0 %h", inst_valid, inst_out, NOP_INST);
    end
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h01000300) begin
      errors++; $display("FAIL redir_hold_next_req: req=%b addr=%h, expected 1 01000300", imem_req, imem_addr);
    end
    for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h01000300 || inst_out !== mem_word(32'h01000300)) begin
      errors++; $display("FAIL redir_hold_word: valid=%b pc=%h inst=%h, expected 1 01000300 %h",
                         inst_valid, pc_out, inst_out, mem_word(32'h01000300));
    end
  endtask

  task automatic test_misalign();
    mem_lat = 3;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    @(posedge clk); #1;
    redirect_en = 1'b1; redirect_pc = 32'h01000102;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_enter: err=%b req=%b valid=%b, expected 1 0 0", misalign_err, imem_req, inst_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      redirect_en = (i == 3);
      redirect_pc = 32'h01000400;
      @(negedge clk);
      checks++;
      if (misalign_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL misalign_sticky%0d: err=%b req=%b valid=%b, expected 1 0 0", i, misalign_err, imem_req, inst_valid);
      end
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_cleared: err=%b, expected 0", misalign_err); end
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL misalign_resume: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    redirect_en = 1'b1; redirect_pc = 32'hFFFFFFFC;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'hFFFFFFFC || inst_out !== mem_word(32'hFFFFFFFC)) begin
      errors++; $display("FAIL wrap_word: valid=%b pc=%h inst=%h, expected 1 fffffffc %h",
                         inst_valid, pc_out, inst_out, mem_word(32'hFFFFFFFC));
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h00000000) begin
      errors++; $display("FAIL wrap_next_addr: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    mem_lat = 3;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 30 && !(imem_req && imem_addr === RESET_PC + 32'd4); i++) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd4) begin
      errors++; $display("FAIL async_setup: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RESET_PC + 32'd4);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || pc_out !== RESET_PC || inst_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: req=%b addr=%h pc=%h valid=%b, expected 0 %h %h 0",
                         imem_req, imem_addr, pc_out, inst_valid, RESET_PC, RESET_PC);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL async_restart: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr;
    logic prev_pend, last_redir;
    int accepted;
    do_reset();
    exp_pc = RESET_PC; prev_addr = 32'h0; prev_pend = 1'b0; last_redir = 1'b0; accepted = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect_en = 1'b0;
      if (!last_redir && $urandom_range(0, 14) == 0) begin
        redirect_en = 1'b1;
        if ($urandom_range(0, 5) == 0) redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(0, 3) << 2);
        else                           redirect_pc = RESET_PC + 32'($urandom_range(0, 1023) << 2);
      end
      last_redir = redirect_en;
      @(negedge clk);
      if (prev_pend && imem_req) begin
        checks++;
        if (imem_addr !== prev_addr) begin
          errors++; $display("FAIL rand_addr_stable cyc %0d: addr=%h, expected %h", cyc, imem_addr, prev_addr);
        end
      end
      if (!inst_valid) begin
        checks++;
        if (inst_out !== NOP_INST) begin
          errors++; $display("FAIL rand_nop cyc %0d: inst=%h, expected %h", cyc, inst_out, NOP_INST);
        end
      end
      if (inst_valid && inst_ready && !redirect_en) begin
        checks++;
        if (pc_out !== exp_pc || inst_out !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rand_accept cyc %0d: pc=%h inst=%h, expected pc=%h inst=%h",
                             cyc, pc_out, inst_out, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      if (redirect_en) exp_pc = redirect_pc;
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      mem_lat = $urandom_range(1, 4);
    end
    @(posedge clk); #1;
    redirect_en = 1'b0;
    checks++;
    if (accepted < 80 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL rand_progress: accepted=%0d err=%b, expected >=80 and 0", accepted, misalign_err);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_req();
    test_redirect_ack();
    test_redirect_hold();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
